// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the multi-port register file.
package reg_file_pkg;
   localparam int DATA_WL = 16;
   localparam int ADR_WL  = 4;
   localparam int REG_CNT = 16;

   typedef logic [DATA_WL-1:0] reg_data_t;
   typedef logic [ADR_WL-1:0]  reg_adr_t;

   localparam reg_data_t RST_VAL = 16'd10;
endpackage

// File: rtl/reg_file_mp_read_port.sv
// One asynchronous read port: storage lookup, ZERO_REG masking and,
// with REG_FILE_MP_BYPASS_EN defined, same-cycle write-to-read forwarding.
module reg_file_mp_read_port #(
   parameter int DATA_WL  = 16,
   parameter int ADR_WL   = 4,
   parameter int REG_CNT  = 16,
   parameter int ZERO_REG = 0
) (
   input  logic [ADR_WL-1:0]               adr,
   input  logic [REG_CNT-1:0][DATA_WL-1:0] mem,
   input  logic [REG_CNT-1:0]              busy,
   input  logic                            w0_we,
   input  logic [ADR_WL-1:0]               w0_adr,
   input  logic [DATA_WL-1:0]              w0_data,
   input  logic                            w1_we,
   input  logic [ADR_WL-1:0]               w1_adr,
   input  logic [DATA_WL-1:0]              w1_data,
   input  logic                            rsv,
   input  logic [ADR_WL-1:0]               rsv_adr,
   output logic [DATA_WL-1:0]              data,
   output logic                            bsy
);

`ifndef REG_FILE_MP_BYPASS_EN
   // Write and reserve inputs only matter when forwarding is built in.
   logic unused_wr;
   assign unused_wr = ^{w0_we, w0_adr, w0_data, w1_we, w1_adr, w1_data, rsv, rsv_adr};
`endif

   // Stored value, optionally overridden by an in-flight write (W1 wins), then zero-masked.
   always_comb begin
      data = mem[adr];
      bsy  = busy[adr];
`ifdef REG_FILE_MP_BYPASS_EN
      if (w1_we && w1_adr == adr) begin
         data = w1_data;
         bsy  = rsv && rsv_adr == adr;
      end else if (w0_we && w0_adr == adr) begin
         data = w0_data;
         bsy  = rsv && rsv_adr == adr;
      end
`endif
      if (ZERO_REG != 0 && adr == '0) begin
         data = '0;
         bsy  = 1'b0;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with per-register busy scoreboard.
// Optional build macro: REG_FILE_MP_BYPASS_EN (same-cycle write-to-read forwarding).
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int                 DATA_WL  = reg_file_pkg::DATA_WL,
   parameter int                 ADR_WL   = reg_file_pkg::ADR_WL,
   parameter int                 REG_CNT  = reg_file_pkg::REG_CNT,
   parameter logic [DATA_WL-1:0] RST_VAL  = reg_file_pkg::RST_VAL,
   parameter int                 ZERO_REG = 0
) (
   input  logic               clk,
   input  logic               a_reset_l,
   input  logic [ADR_WL-1:0]  a_adr_in,
   input  logic [ADR_WL-1:0]  b_adr_in,
   output logic [DATA_WL-1:0] reg_a_out,
   output logic [DATA_WL-1:0] reg_b_out,
   output logic               a_busy,
   output logic               b_busy,
   input  logic               w0_we,
   input  logic [ADR_WL-1:0]  w0_adr_in,
   input  logic [DATA_WL-1:0] w0_data_in,
   input  logic               w1_we,
   input  logic [ADR_WL-1:0]  w1_adr_in,
   input  logic [DATA_WL-1:0] w1_data_in,
   input  logic               rsv,
   input  logic [ADR_WL-1:0]  rsv_adr_in
);

   localparam int NUM_RD = 2;

   logic [REG_CNT-1:0][DATA_WL-1:0] mem;
   logic [REG_CNT-1:0]              busy;
   logic [REG_CNT-1:0]              w0_hit, w1_hit, rsv_hit;

   // Per-register write/reserve decode; register 0 is never targeted when hardwired to zero.
   always_comb begin
      w0_hit  = '0;
      w1_hit  = '0;
      rsv_hit = '0;
      for (int r = 0; r < REG_CNT; r++) begin
         if (ZERO_REG == 0 || r != 0) begin
            w0_hit[r]  = w0_we && (w0_adr_in == ADR_WL'(r));
            w1_hit[r]  = w1_we && (w1_adr_in == ADR_WL'(r));
            rsv_hit[r] = rsv && (rsv_adr_in == ADR_WL'(r));
         end
      end
   end

   // Storage and scoreboard: W1 beats W0 on data, a new reservation beats a completing write.
   always_ff @(posedge clk or negedge a_reset_l) begin
      if (!a_reset_l) begin
         mem  <= {REG_CNT{RST_VAL}};
         busy <= '0;
      end else begin
         for (int r = 0; r < REG_CNT; r++) begin
            if (w1_hit[r])      mem[r] <= w1_data_in;
            else if (w0_hit[r]) mem[r] <= w0_data_in;

            if (rsv_hit[r])                  busy[r] <= 1'b1;
            else if (w0_hit[r] || w1_hit[r]) busy[r] <= 1'b0;
         end
      end
   end

   logic [NUM_RD-1:0][ADR_WL-1:0]  rd_adr;
   logic [NUM_RD-1:0][DATA_WL-1:0] rd_data;
   logic [NUM_RD-1:0]              rd_busy;

   assign rd_adr    = {b_adr_in, a_adr_in};
   assign reg_a_out = rd_data[0];
   assign reg_b_out = rd_data[1];
   assign a_busy    = rd_busy[0];
   assign b_busy    = rd_busy[1];

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      reg_file_mp_read_port #(
         .DATA_WL (DATA_WL),
         .ADR_WL  (ADR_WL),
         .REG_CNT (REG_CNT),
         .ZERO_REG(ZERO_REG)
      ) u_rd (
         .adr    (rd_adr[p]),
         .mem    (mem),
         .busy   (busy),
         .w0_we  (w0_we),
         .w0_adr (w0_adr_in),
         .w0_data(w0_data_in),
         .w1_we  (w1_we),
         .w1_adr (w1_adr_in),
         .w1_data(w1_data_in),
         .rsv    (rsv),
         .rsv_adr(rsv_adr_in),
         .data   (rd_data[p]),
         .bsy    (rd_busy[p])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default and ZERO_REG=1 instances).
`timescale 1ns/100ps
module tb_reg_file_mp;
   logic        clk = 1'b0;
   logic        a_reset_l;
   logic [3:0]  a_adr_in, b_adr_in, w0_adr_in, w1_adr_in, rsv_adr_in;
   logic [15:0] w0_data_in, w1_data_in;
   logic        w0_we, w1_we, rsv;
   logic [15:0] reg_a_out, reg_b_out, z_reg_a_out, z_reg_b_out;
   logic        a_busy, b_busy, z_a_busy, z_b_busy;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   reg_file_mp dut (
      .clk(clk), .a_reset_l(a_reset_l),
      .a_adr_in(a_adr_in), .b_adr_in(b_adr_in),
      .reg_a_out(reg_a_out), .reg_b_out(reg_b_out),
      .a_busy(a_busy), .b_busy(b_busy),
      .w0_we(w0_we), .w0_adr_in(w0_adr_in), .w0_data_in(w0_data_in),
      .w1_we(w1_we), .w1_adr_in(w1_adr_in), .w1_data_in(w1_data_in),
      .rsv(rsv), .rsv_adr_in(rsv_adr_in)
   );

   reg_file_mp #(.ZERO_REG(1)) dut_z (
      .clk(clk), .a_reset_l(a_reset_l),
      .a_adr_in(a_adr_in), .b_adr_in(b_adr_in),
      .reg_a_out(z_reg_a_out), .reg_b_out(z_reg_b_out),
      .a_busy(z_a_busy), .b_busy(z_b_busy),
      .w0_we(w0_we), .w0_adr_in(w0_adr_in), .w0_data_in(w0_data_in),
      .w1_we(w1_we), .w1_adr_in(w1_adr_in), .w1_data_in(w1_data_in),
      .rsv(rsv), .rsv_adr_in(rsv_adr_in)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      w0_we = 1'b0; w1_we = 1'b0; rsv = 1'b0;
   endtask

   task automatic test_reset();
      // dirty some state first so reset has something to undo
      w0_we = 1'b1; w0_adr_in = 4'd4; w0_data_in = 16'h4444;
      rsv = 1'b1; rsv_adr_in = 4'd6;
      tick(); idle();
      a_adr_in = 4'd4; b_adr_in = 4'd6; #1;
      total++;
      if (reg_a_out !== 16'h4444 || b_busy !== 1'b1) $display("FAIL pre_reset got %h/%b exp 4444/1", reg_a_out, b_busy);
      else passed++;
      @(negedge clk);
      #0.5 a_reset_l = 1'b0;
      for (int i = 0; i < 16; i++) begin
         a_adr_in = 4'(i); b_adr_in = 4'(15 - i);
         #0.2;
         total++;
         if (reg_a_out !== 16'd10 || a_busy !== 1'b0 || reg_b_out !== 16'd10 || b_busy !== 1'b0)
            $display("FAIL reset_read[%0d] got a=%h/%b b=%h/%b exp 000a/0", i, reg_a_out, a_busy, reg_b_out, b_busy);
         else passed++;
      end
      tick();
      a_reset_l = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      logic [15:0] exp_same;
`ifdef REG_FILE_MP_BYPASS_EN
      exp_same = 16'h1234;
`else
      exp_same = 16'd10;
`endif
      w0_we = 1'b1; w0_adr_in = 4'd3; w0_data_in = 16'h1234; a_adr_in = 4'd3; #1;
      total++;
      if (reg_a_out !== exp_same) $display("FAIL wr_same_cycle got %h exp %h", reg_a_out, exp_same);
      else passed++;
      tick(); idle(); #1;
      total++;
      if (reg_a_out !== 16'h1234) $display("FAIL wr_next_cycle got %h exp 1234", reg_a_out);
      else passed++;
   endtask

   task automatic test_collision();
      w0_we = 1'b1; w0_adr_in = 4'd7; w0_data_in = 16'hAAAA;
      w1_we = 1'b1; w1_adr_in = 4'd7; w1_data_in = 16'h5555;
      tick(); idle(); a_adr_in = 4'd7; #1;
      total++;
      if (reg_a_out !== 16'h5555) $display("FAIL collision_same got %h exp 5555", reg_a_out);
      else passed++;
      w0_we = 1'b1; w0_adr_in = 4'd1; w0_data_in = 16'h1111;
      w1_we = 1'b1; w1_adr_in = 4'd2; w1_data_in = 16'h2222;
      tick(); idle(); a_adr_in = 4'd1; b_adr_in = 4'd2; #1;
      total++;
      if (reg_a_out !== 16'h1111 || reg_b_out !== 16'h2222)
         $display("FAIL collision_diff got %h/%h exp 1111/2222", reg_a_out, reg_b_out);
      else passed++;
   endtask

   task automatic test_scoreboard();
      logic exp_b;
`ifdef REG_FILE_MP_BYPASS_EN
      exp_b = 1'b0;
`else
      exp_b = 1'b1;
`endif
      rsv = 1'b1; rsv_adr_in = 4'd5; a_adr_in = 4'd5; #1;
      total++;
      if (a_busy !== 1'b0) $display("FAIL rsv_before_edge got %b exp 0", a_busy);
      else passed++;
      tick(); idle(); #1;
      total++;
      if (a_busy !== 1'b1) $display("FAIL rsv_set got %b exp 1", a_busy);
      else passed++;
      w1_we = 1'b1; w1_adr_in = 4'd5; w1_data_in = 16'h0505; #1;
      total++;
      if (a_busy !== exp_b) $display("FAIL clr_same_cycle got %b exp %b", a_busy, exp_b);
      else passed++;
      tick(); idle(); #1;
      total++;
      if (a_busy !== 1'b0 || reg_a_out !== 16'h0505) $display("FAIL clr got %b/%h exp 0/0505", a_busy, reg_a_out);
      else passed++;
      rsv = 1'b1; rsv_adr_in = 4'd5; w0_we = 1'b1; w0_adr_in = 4'd5; w0_data_in = 16'h5A5A;
      tick(); idle(); #1;
      total++;
      if (a_busy !== 1'b1 || reg_a_out !== 16'h5A5A) $display("FAIL set_wins got %b/%h exp 1/5a5a", a_busy, reg_a_out);
      else passed++;
      rsv = 1'b1; rsv_adr_in = 4'd5;
      tick(); idle(); #1;
      total++;
      if (a_busy !== 1'b1) $display("FAIL rsv_twice got %b exp 1", a_busy);
      else passed++;
      w0_we = 1'b1; w0_adr_in = 4'd8; w0_data_in = 16'h0808; a_adr_in = 4'd8;
      tick(); idle(); #1;
      total++;
      if (a_busy !== 1'b0 || reg_a_out !== 16'h0808) $display("FAIL wr_not_busy got %b/%h exp 0/0808", a_busy, reg_a_out);
      else passed++;
   endtask

   task automatic test_zero_reg();
      b_adr_in = 4'd0; a_adr_in = 4'd0; #1;
      total++;
      if (z_reg_b_out !== 16'h0000 || z_b_busy !== 1'b0) $display("FAIL zero_rst got %h/%b exp 0000/0", z_reg_b_out, z_b_busy);
      else passed++;
      total++;
      if (reg_b_out !== 16'd10) $display("FAIL r0_rst_normal got %h exp 000a", reg_b_out);
      else passed++;
      w0_we = 1'b1; w0_adr_in = 4'd0; w0_data_in = 16'hFFFF; rsv = 1'b1; rsv_adr_in = 4'd0;
      tick(); idle(); #1;
      total++;
      if (z_reg_b_out !== 16'h0000 || z_b_busy !== 1'b0) $display("FAIL zero_wr got %h/%b exp 0000/0", z_reg_b_out, z_b_busy);
      else passed++;
      total++;
      if (reg_b_out !== 16'hFFFF || b_busy !== 1'b1) $display("FAIL r0_wr_normal got %h/%b exp ffff/1", reg_b_out, b_busy);
      else passed++;
      // nonzero registers of the ZERO_REG instance still behave normally
      a_adr_in = 4'd3; #1;
      total++;
      if (z_reg_a_out !== 16'h1234) $display("FAIL zero_inst_r3 got %h exp 1234", z_reg_a_out);
      else passed++;
   endtask

   task automatic test_reset_mid();
      rsv = 1'b1; rsv_adr_in = 4'd9; w0_we = 1'b1; w0_adr_in = 4'd9; w0_data_in = 16'hBEEF;
      a_adr_in = 4'd9;
      tick(); idle(); #1;
      total++;
      if (reg_a_out !== 16'hBEEF || a_busy !== 1'b1) $display("FAIL r9_before got %h/%b exp beef/1", reg_a_out, a_busy);
      else passed++;
      a_reset_l = 1'b0; #1;
      total++;
      if (reg_a_out !== 16'd10 || a_busy !== 1'b0) $display("FAIL r9_reset got %h/%b exp 000a/0", reg_a_out, a_busy);
      else passed++;
      w0_we = 1'b1; w0_adr_in = 4'd9; w0_data_in = 16'h1111; rsv = 1'b1;
      tick(); #1;
      total++;
      if (reg_a_out !== 16'd10 || a_busy !== 1'b0) $display("FAIL wr_in_reset got %h/%b exp 000a/0", reg_a_out, a_busy);
      else passed++;
      idle(); #1;
      a_reset_l = 1'b1;
      tick(); #1;
      total++;
      if (reg_a_out !== 16'd10 || a_busy !== 1'b0) $display("FAIL after_release got %h/%b exp 000a/0", reg_a_out, a_busy);
      else passed++;
   endtask

   initial begin
      a_reset_l = 1'b0;
      a_adr_in = '0; b_adr_in = '0; w0_adr_in = '0; w1_adr_in = '0; rsv_adr_in = '0;
      w0_data_in = '0; w1_data_in = '0;
      idle();
      #12 a_reset_l = 1'b1;
      tick();
      test_reset();
      test_write_read();
      test_collision();
      test_scoreboard();
      test_zero_reg();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
